llki_key_rx_fsm: RTL and testbench
==================================

Name: llki_key_rx_fsm

Overview:
- Key-receive stage sitting directly upstream of the LLKI-wrapped IIR filter core.
- Accepts key-load, key-clear and status requests from the LLKI request/response channel.
- Assembles a KEY_WORDS x WORD_W key and presents it to the core's input-masking logic with a key_valid qualifier.
- Zeroizes key storage on clear, then answers every request with a status response.

Parameters:
- KEY_WORDS, 2, number of key words in a complete key.
- WORD_W, 64, width of one key word and of the request/response data.
- CNT_W, 2, width of the word counter; must satisfy 2^CNT_W > KEY_WORDS.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_opcode  in  3  1=LOAD_WORD, 2=CLEAR, 3=STATUS, others illegal.
- req_data  in  WORD_W  key word for LOAD_WORD; ignored otherwise.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes response.
- resp_status  out  2  0=OK, 1=ERR_BADOP, 2=ERR_OVERFLOW.
- resp_data  out  WORD_W  STATUS payload; zero for other opcodes.
- key_out  out  KEY_WORDS*WORD_W  assembled key; word 0 in MSBs.
- key_valid  out  1  all KEY_WORDS words loaded.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; key registers=0; word_cnt=0.
  - key_valid=0; req_ready=0 while reset is asserted, 1 in the first cycle after release.
  - resp_valid=0, resp_status=0, resp_data=0.
- Reset asserted mid-operation (any state) aborts the operation, clears the key, and drops any pending response.
- States: IDLE, CLEAR, RESP.
- IDLE:
  - req_ready=1.
  - Handshake when req_valid and req_ready are high on the same rising edge (cycle T).
  - The operation executes on that edge, with one exception: CLEAR.
  - resp_valid rises at T+1; state -> RESP.
- LOAD_WORD:
  - If word_cnt<KEY_WORDS: key[word_cnt]<=req_data, word_cnt++, status OK.
  - When word_cnt reaches KEY_WORDS, key_valid goes to 1 at T+1.
  - If word_cnt==KEY_WORDS: storage unchanged, status ERR_OVERFLOW. A key cannot be overwritten without a CLEAR.
- CLEAR:
  - Edge T: key_valid<=0 and word_cnt<=0; state -> CLEAR.
  - CLEAR zeroizes one word per cycle, index 0..KEY_WORDS-1, using an internal index counter.
  - After the last word: state -> RESP, status OK.
  - resp_valid rises at T+1+KEY_WORDS.
  - req_ready=0 throughout CLEAR.
- STATUS:
  - No state change.
  - resp_data = zero-extended {word_cnt, key_valid}, with key_valid in bit 0 and word_cnt in bits CNT_W:1.
  - status OK.
- Illegal opcode (0, 4-7): no state change, status ERR_BADOP.
- RESP:
  - req_ready=0.
  - resp_valid, resp_status and resp_data are held stable until resp_ready=1 on a rising edge.
  - On that edge: resp_valid<=0, state -> IDLE.
  - A new request can be accepted one cycle after the response is taken.
  - resp_ready is ignored outside RESP.
- key_out:
  - Equals the concatenation of the key registers when key_valid=1, otherwise all zeros.
  - A partial key never reaches the core.
- key_valid changes only on a LOAD_WORD that completes the key (0->1), on CLEAR entry (1->0), or on reset.
- Simultaneous events: req_valid high during CLEAR/RESP is not accepted (req_ready=0); the requester holds it. No request queueing; at most one request in flight.

Test Plan:
- Reset, then LOAD_WORD 0x0123456789ABCDEF and LOAD_WORD 0xFEDCBA9876543210, each response taken immediately:
  - resp_valid 1 cycle after each accept, status OK.
  - key_valid=1 after the second word.
  - key_out=0x0123456789ABCDEFFEDCBA9876543210.
- With a full key, a third LOAD_WORD 0x1111111111111111 -> status ERR_OVERFLOW; key_out unchanged; key_valid=1.
- Load one word only, then STATUS:
  - resp_data=0x2 (word_cnt=1, key_valid=0).
  - key_out=0.
- With a full key, CLEAR accepted at cycle T:
  - key_valid=0 at T+1.
  - req_ready=0 through T+2.
  - resp_valid at T+3, status OK.
  - Following STATUS returns 0x0.
- Opcode 5 -> ERR_BADOP with no state change. Then hold resp_ready=0 for 10 cycles: response held stable and req_ready=0; after resp_ready=1, req_ready=1 on the next cycle.
- After loading one word, assert reset mid-CLEAR and mid-RESP:
  - All outputs return to reset values asynchronously.
  - After release, STATUS returns 0x0.

Source files
------------

// File: rtl/llki_key_rx_fsm.sv
// LLKI key-receive stage: assembles a KEY_WORDS x WORD_W key from LOAD_WORD requests,
// zeroizes it word by word on CLEAR, and answers every request with a status response.
module llki_key_rx_fsm #(
    parameter int KEY_WORDS = 2,
    parameter int WORD_W    = 64,
    parameter int CNT_W     = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [2:0]                  req_opcode,
    input  logic [WORD_W-1:0]           req_data,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [1:0]                  resp_status,
    output logic [WORD_W-1:0]           resp_data,
    output logic [KEY_WORDS*WORD_W-1:0] key_out,
    output logic                        key_valid
);

    typedef enum logic [1:0] {IDLE, CLEAR, RESP} state_t;

    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_CLEAR  = 3'd2;
    localparam logic [2:0] OP_STATUS = 3'd3;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_BADOP    = 2'd1;
    localparam logic [1:0] ST_OVERFLOW = 2'd2;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(KEY_WORDS - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(KEY_WORDS);

    state_t                             state;
    logic [KEY_WORDS-1:0][WORD_W-1:0]   key_q;
    logic [CNT_W-1:0]                   word_cnt;
    logic [CNT_W-1:0]                   clr_idx;
    logic [KEY_WORDS*WORD_W-1:0]        key_cat;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            key_q       <= '0;
            word_cnt    <= '0;
            clr_idx     <= '0;
            key_valid   <= 1'b0;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_status <= ST_OK;
            resp_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready   <= 1'b0;
                        resp_valid  <= 1'b1;
                        resp_status <= ST_OK;
                        resp_data   <= '0;
                        state       <= RESP;
                        case (req_opcode)
                            OP_LOAD: begin
                                if (word_cnt < FULL) begin
                                    for (int i = 0; i < KEY_WORDS; i++)
                                        if (word_cnt == CNT_W'(i)) key_q[i] <= req_data;
                                    word_cnt <= word_cnt + 1'b1;
                                    if (word_cnt == LAST) key_valid <= 1'b1;
                                end else begin
                                    resp_status <= ST_OVERFLOW;
                                end
                            end
                            OP_CLEAR: begin
                                // Response is deferred until every word has been zeroized.
                                key_valid  <= 1'b0;
                                word_cnt   <= '0;
                                clr_idx    <= '0;
                                resp_valid <= 1'b0;
                                state      <= CLEAR;
                            end
                            OP_STATUS: resp_data <= WORD_W'({word_cnt, key_valid});
                            default:   resp_status <= ST_BADOP;
                        endcase
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                CLEAR: begin
                    for (int i = 0; i < KEY_WORDS; i++)
                        if (clr_idx == CNT_W'(i)) key_q[i] <= '0;
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == LAST) begin
                        state       <= RESP;
                        resp_valid  <= 1'b1;
                        resp_status <= ST_OK;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word 0 lands in the MSBs; a partial key is masked so it never reaches the core.
    always_comb begin
        key_cat = '0;
        for (int i = 0; i < KEY_WORDS; i++)
            key_cat[(KEY_WORDS-1-i)*WORD_W +: WORD_W] = key_q[i];
        key_out = key_valid ? key_cat : '0;
    end

endmodule

// File: tb/tb_llki_key_rx_fsm.sv
// Scoreboard bench for llki_key_rx_fsm: directed plan followed by randomized requests
// checked against a word-list reference model.
module tb_llki_key_rx_fsm;
    localparam int K = 2;
    localparam int W = 64;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [2:0]     req_opcode = '0;
    logic [W-1:0]   req_data = '0;
    logic           resp_valid;
    logic           resp_ready = 1'b1;
    logic [1:0]     resp_status;
    logic [W-1:0]   resp_data;
    logic [K*W-1:0] key_out;
    logic           key_valid;

    llki_key_rx_fsm #(.KEY_WORDS(K), .WORD_W(W), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_data(req_data), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_status(resp_status), .resp_data(resp_data),
        .key_out(key_out), .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   st;
        logic [W-1:0] d;
    } exp_t;

    exp_t         sbq[$];
    exp_t         mon_e;
    int           checks = 0;
    int           passes = 0;
    int           m_cnt = 0;
    logic [W-1:0] m_words[K];

    task automatic chk(input string name, input logic [K*W-1:0] act, input logic [K*W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [K*W-1:0] m_key();
        logic [K*W-1:0] r = '0;
        if (m_cnt != K) return '0;
        for (int i = 0; i < K; i++) r = (r << W) | {{(K*W-W){1'b0}}, m_words[i]};
        return r;
    endfunction

    // Monitor: a response is consumed on the edge following a negedge where valid&ready.
    always @(negedge clk) begin
        if (reset && resp_valid && resp_ready) begin
            if (sbq.size() == 0) chk("unexpected_resp", 1, 0);
            else begin
                mon_e = sbq.pop_front();
                chk("resp_status", {{(K*W-2){1'b0}}, resp_status}, {{(K*W-2){1'b0}}, mon_e.st});
                chk("resp_data", {{W{1'b0}}, resp_data}, {{W{1'b0}}, mon_e.d});
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] d);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        if (!req_ready) chk("req_ready_timeout", 0, 1);
        req_valid = 1'b1; req_opcode = op; req_data = d;
        @(posedge clk); #1 req_valid = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input logic [W-1:0] d, input int stall);
        exp_t e;
        int lat;
        bit rr_ok, stable;
        logic [1:0] s0;
        logic [W-1:0] d0;
        e.st = 2'd0; e.d = '0;
        case (op)
            3'd1: if (m_cnt < K) begin m_words[m_cnt] = d; m_cnt++; end else e.st = 2'd2;
            3'd2: begin m_cnt = 0; for (int i = 0; i < K; i++) m_words[i] = '0; end
            3'd3: e.d = W'(m_cnt * 2 + ((m_cnt == K) ? 1 : 0));
            default: e.st = 2'd1;
        endcase
        sbq.push_back(e);
        if (stall > 0) resp_ready = 1'b0;
        issue(op, d);
        lat = 1; rr_ok = 1'b1;
        @(negedge clk);
        if (op == 3'd2) chk("clear_key_valid", {{(K*W-1){1'b0}}, key_valid}, 0);
        while (!resp_valid && lat < 20) begin
            if (req_ready) rr_ok = 1'b0;
            @(negedge clk); lat++;
        end
        if (req_ready) rr_ok = 1'b0;
        chk("resp_latency", (K*W)'(lat), (K*W)'((op == 3'd2) ? 1 + K : 1));
        chk("req_ready_busy", {{(K*W-1){1'b0}}, rr_ok}, 1);
        if (stall > 0) begin
            stable = 1'b1; s0 = resp_status; d0 = resp_data;
            repeat (stall) begin
                @(negedge clk);
                if (!resp_valid || resp_status !== s0 || resp_data !== d0 || req_ready) stable = 1'b0;
            end
            chk("resp_hold", {{(K*W-1){1'b0}}, stable}, 1);
            @(posedge clk); #1 resp_ready = 1'b1;
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("resp_taken", {{(K*W-1){1'b0}}, resp_valid}, 0);
        chk("req_ready_after", {{(K*W-1){1'b0}}, req_ready}, 1);
        chk("key_valid", {{(K*W-1){1'b0}}, key_valid}, {{(K*W-1){1'b0}}, m_cnt == K});
        chk("key_out", key_out, m_key());
    endtask

    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        chk("rst_outputs", {{(K*W-W-5){1'b0}}, req_ready, resp_valid, resp_status, resp_data, key_valid}, 0);
        chk("rst_key_out", key_out, 0);
        sbq.delete();
        m_cnt = 0;
        for (int i = 0; i < K; i++) m_words[i] = '0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [2:0] op;
        int r;
        for (int i = 0; i < K; i++) m_words[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {{(K*W-W-5){1'b0}}, req_ready, resp_valid, resp_status, resp_data, key_valid}, 0);
        chk("reset_key_out", key_out, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("req_ready_post_reset", {{(K*W-1){1'b0}}, req_ready}, 1);

        send(3'd1, 64'h0123456789ABCDEF, 0);
        send(3'd1, 64'hFEDCBA9876543210, 0);
        chk("key_out_plan", key_out, 128'h0123456789ABCDEFFEDCBA9876543210);
        send(3'd1, 64'h1111111111111111, 0);
        chk("key_out_after_ovf", key_out, 128'h0123456789ABCDEFFEDCBA9876543210);
        send(3'd2, '0, 0);
        send(3'd3, '0, 0);
        send(3'd1, 64'hA5A5A5A5A5A5A5A5, 0);
        send(3'd3, '0, 0);
        send(3'd5, 64'hDEAD, 10);

        // Reset during CLEAR.
        issue(3'd2, '0);
        @(negedge clk);
        async_reset();
        send(3'd3, '0, 0);

        // Reset while a response is being held.
        send(3'd1, 64'h0F0F, 0);
        resp_ready = 1'b0;
        issue(3'd1, 64'h1234);
        @(negedge clk);
        async_reset();
        send(3'd3, '0, 0);

        repeat (60) begin
            r = $urandom_range(0, 9);
            if (r < 5)      op = 3'd1;
            else if (r < 7) op = 3'd2;
            else if (r < 9) op = 3'd3;
            else begin
                r = $urandom_range(0, 4);
                op = (r == 0) ? 3'd0 : 3'(r + 3);
            end
            send(op, {$urandom, $urandom}, $urandom_range(0, 3));
        end

        repeat (2) @(negedge clk);
        chk("sb_empty", (K*W)'(sbq.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
